// File: rtl/qspi_arb_if.sv
// Bundle of requester-side and controller-side signals around the QSPI arbiter.
// The arbiter takes the slave view; the requesters plus controller take the master view.
interface qspi_arb_if #(
    parameter int PA          = 24,
    parameter int LINE_LENGTH = 4
);
    localparam int AW = PA - $clog2(LINE_LENGTH);

    logic          ic_req;
    logic          ic_mem;
    logic [AW-1:0] ic_addr;
    logic          ic_strobe;
    logic          ic_done;

    logic          dr_req;
    logic          dr_mem;
    logic [AW-1:0] dr_addr;
    logic          dr_strobe;
    logic          dr_done;

    logic          dw_req;
    logic          dw_mem;
    logic [AW-1:0] dw_addr;
    logic [3:0]    dw_data;
    logic          dw_rstrobe;
    logic          dw_done;

    logic          q_req;
    logic          q_i_d;
    logic          q_mem;
    logic          q_write;
    logic [AW-1:0] q_paddr;
    logic [3:0]    q_dwrite;
    logic          q_wstrobe_i;
    logic          q_wstrobe_d;
    logic          q_rstrobe_d;

    logic          err;

    modport slave (
        input  ic_req, ic_mem, ic_addr,
        input  dr_req, dr_mem, dr_addr,
        input  dw_req, dw_mem, dw_addr, dw_data,
        input  q_wstrobe_i, q_wstrobe_d, q_rstrobe_d,
        output ic_strobe, ic_done,
        output dr_strobe, dr_done,
        output dw_rstrobe, dw_done,
        output q_req, q_i_d, q_mem, q_write, q_paddr, q_dwrite,
        output err
    );

    modport master (
        output ic_req, ic_mem, ic_addr,
        output dr_req, dr_mem, dr_addr,
        output dw_req, dw_mem, dw_addr, dw_data,
        output q_wstrobe_i, q_wstrobe_d, q_rstrobe_d,
        input  ic_strobe, ic_done,
        input  dr_strobe, dr_done,
        input  dw_rstrobe, dw_done,
        input  q_req, q_i_d, q_mem, q_write, q_paddr, q_dwrite,
        input  err
    );
endinterface

// File: rtl/qspi_arb.sv
// Shares one QSPI channel between icache fill, dcache fill and dcache writeback,
// holding the command for a whole burst and counting nibble strobes to find its end.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no owner; arbitrate and latch the winning command
// S_RD      | read burst owned by ic or dr; forward controller strobes
// S_WR      | write burst owned by dw; pass writeback nibbles through
// S_WR_TAIL | one cycle covering the controller's CS-release state
module qspi_arb #(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 24,
    parameter int MAX_D       = 4
) (
    input  logic       clk,
    input  logic       reset,
    qspi_arb_if.slave  bus
);
    localparam int AW = PA - $clog2(LINE_LENGTH);
    localparam int NW = $clog2(2 * LINE_LENGTH);
    localparam int DW = $clog2(MAX_D + 1);
    localparam logic [NW-1:0] NCNT_LAST  = NW'(2 * LINE_LENGTH - 1);
    localparam logic [DW-1:0] DCOUNT_MAX = DW'(MAX_D);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WR_TAIL} state_e;
    typedef enum logic [1:0] {OWN_IC, OWN_DR, OWN_DW} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          q_req_q, q_req_d;
    logic          q_i_d_q, q_i_d_d;
    logic          q_mem_q, q_mem_d;
    logic          q_write_q, q_write_d;
    logic [AW-1:0] q_paddr_q, q_paddr_d;
    logic          ic_done_q, ic_done_d;
    logic          dr_done_q, dr_done_d;
    logic          dw_done_q, dw_done_d;
    logic          err_q, err_d;
    logic [NW-1:0] ncnt_q, ncnt_d;
    logic [DW-1:0] dcount_q, dcount_d;

    logic          grant_vld;
    owner_e        grant_own;
    logic          any_strobe;
    logic          rd_match;
    logic          strobe_bad;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        q_req_d    = q_req_q;
        q_i_d_d    = q_i_d_q;
        q_mem_d    = q_mem_q;
        q_write_d  = q_write_q;
        q_paddr_d  = q_paddr_q;
        ic_done_d  = 1'b0;
        dr_done_d  = 1'b0;
        dw_done_d  = 1'b0;
        ncnt_d     = ncnt_q;
        dcount_d   = dcount_q;
        grant_vld  = 1'b0;
        grant_own  = OWN_IC;
        rd_match   = 1'b0;
        strobe_bad = 1'b0;
        any_strobe = bus.q_wstrobe_i | bus.q_wstrobe_d | bus.q_rstrobe_d;

        case (state_q)
            S_IDLE: begin
                strobe_bad = any_strobe;
                if (!bus.ic_req) dcount_d = '0;
                // A waiting ifetch that has already lost MAX_D times jumps the queue
                if (bus.ic_req && dcount_q == DCOUNT_MAX) begin
                    grant_vld = 1'b1;
                    grant_own = OWN_IC;
                end else if (bus.dw_req) begin
                    grant_vld = 1'b1;
                    grant_own = OWN_DW;
                end else if (bus.dr_req) begin
                    grant_vld = 1'b1;
                    grant_own = OWN_DR;
                end else if (bus.ic_req) begin
                    grant_vld = 1'b1;
                    grant_own = OWN_IC;
                end

                if (grant_vld) begin
                    owner_d   = grant_own;
                    q_req_d   = 1'b1;
                    ncnt_d    = '0;
                    q_write_d = (grant_own == OWN_DW);
                    q_i_d_d   = (grant_own == OWN_IC);
                    case (grant_own)
                        OWN_DW: begin
                            q_mem_d   = bus.dw_mem;
                            q_paddr_d = bus.dw_addr;
                        end
                        OWN_DR: begin
                            q_mem_d   = bus.dr_mem;
                            q_paddr_d = bus.dr_addr;
                        end
                        default: begin
                            q_mem_d   = bus.ic_mem;
                            q_paddr_d = bus.ic_addr;
                        end
                    endcase
                    state_d = (grant_own == OWN_DW) ? S_WR : S_RD;
                    if (grant_own == OWN_IC) begin
                        dcount_d = '0;
                    end else if (bus.ic_req && dcount_q != DCOUNT_MAX) begin
                        dcount_d = dcount_q + 1'b1;
                    end
                end
            end

            S_RD: begin
                if (owner_q == OWN_IC) begin
                    rd_match   = bus.q_wstrobe_i;
                    strobe_bad = bus.q_wstrobe_d | bus.q_rstrobe_d;
                end else begin
                    rd_match   = bus.q_wstrobe_d;
                    strobe_bad = bus.q_wstrobe_i | bus.q_rstrobe_d;
                end
                if (rd_match) begin
                    ncnt_d = ncnt_q + 1'b1;
                    if (ncnt_q == NCNT_LAST) begin
                        ncnt_d    = '0;
                        q_req_d   = 1'b0;
                        ic_done_d = (owner_q == OWN_IC);
                        dr_done_d = (owner_q != OWN_IC);
                        state_d   = S_IDLE;
                    end
                end
            end

            S_WR: begin
                strobe_bad = bus.q_wstrobe_i | bus.q_wstrobe_d;
                if (bus.q_rstrobe_d) begin
                    ncnt_d = ncnt_q + 1'b1;
                    if (ncnt_q == NCNT_LAST) begin
                        ncnt_d    = '0;
                        q_req_d   = 1'b0;
                        dw_done_d = 1'b1;
                        state_d   = S_WR_TAIL;
                    end
                end
            end

            S_WR_TAIL: begin
                strobe_bad = any_strobe;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = err_q | strobe_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_IC;
            q_req_q   <= 1'b0;
            q_i_d_q   <= 1'b0;
            q_mem_q   <= 1'b0;
            q_write_q <= 1'b0;
            q_paddr_q <= '0;
            ic_done_q <= 1'b0;
            dr_done_q <= 1'b0;
            dw_done_q <= 1'b0;
            err_q     <= 1'b0;
            ncnt_q    <= '0;
            dcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            q_req_q   <= q_req_d;
            q_i_d_q   <= q_i_d_d;
            q_mem_q   <= q_mem_d;
            q_write_q <= q_write_d;
            q_paddr_q <= q_paddr_d;
            ic_done_q <= ic_done_d;
            dr_done_q <= dr_done_d;
            dw_done_q <= dw_done_d;
            err_q     <= err_d;
            ncnt_q    <= ncnt_d;
            dcount_q  <= dcount_d;
        end
    end

    assign bus.q_req      = q_req_q;
    assign bus.q_i_d      = q_i_d_q;
    assign bus.q_mem      = q_mem_q;
    assign bus.q_write    = q_write_q;
    assign bus.q_paddr    = q_paddr_q;
    assign bus.ic_done    = ic_done_q;
    assign bus.dr_done    = dr_done_q;
    assign bus.dw_done    = dw_done_q;
    assign bus.err        = err_q;

    assign bus.ic_strobe  = (state_q == S_RD) && (owner_q == OWN_IC) && bus.q_wstrobe_i;
    assign bus.dr_strobe  = (state_q == S_RD) && (owner_q != OWN_IC) && bus.q_wstrobe_d;
    assign bus.dw_rstrobe = (state_q == S_WR) && bus.q_rstrobe_d;
    assign bus.q_dwrite   = (state_q == S_WR) ? bus.dw_data : 4'h0;
endmodule

// File: doc/qspi_arb.md
# qspi_arb

Three-way arbiter and sequencer in front of the `qspi` flash/PSRAM controller. It shares the single QSPI channel between the instruction-cache fill, data-cache fill and data-cache writeback requesters. It registers the winning request and holds `req` and the command fields stable for the whole burst. It counts the controller's nibble strobes to detect the end of the burst, which the controller does not signal itself, and returns a one-cycle `done` to the owner.

## Interface
- `LINE_LENGTH`, 4: cache line bytes; burst is 2*LINE_LENGTH nibbles.
- `PA`, 24: physical address width.
- `MAX_D`, 4: consecutive data grants allowed while an ifetch waits.
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high.
- `ic_req`, `ic_mem`  in  1  ifetch fill request; target select (0 RAM, 1 ROM).
- `ic_addr`  in  PA-$clog2(LINE_LENGTH)  ifetch line address.
- `ic_strobe`, `ic_done`  out  1  nibble-valid strobe; burst complete.
- `dr_req`, `dr_mem`, `dr_addr`, `dr_strobe`, `dr_done`: same set of signals for the dcache fill.
- `dw_req`, `dw_mem`, `dw_addr`, `dw_done`: same set of signals for the dcache writeback.
- `dw_data`  in  4  writeback nibble.
- `dw_rstrobe`  out  1  writeback nibble consumed.
- `q_req`, `q_i_d`, `q_mem`, `q_write`  out  1  to the controller; `q_i_d` is 1 for ifetch.
- `q_paddr`  out  PA-$clog2(LINE_LENGTH)  to the controller.
- `q_dwrite`  out  4  to the controller.
- `q_wstrobe_i`, `q_wstrobe_d`, `q_rstrobe_d`  in  1  from the controller.
- `err`  out  1  sticky protocol error.

## Operation
- **States**
  - IDLE
  - RD (read burst owned)
  - WR (write burst owned)
  - WR_TAIL (one cycle covering the controller's CS-release state)
- **Requester contract:** `*_req` is a level. `*_mem` and `*_addr` stay stable until the matching `*_done`. The requester drops `*_req` in the `*_done` cycle or later.
- **Arbitration (IDLE only), priority order:**
  - `dw` first.
  - Then `dr`.
  - Then `ic`.
  - Exception: if `ic_req` is pending and `dcount == MAX_D`, `ic` wins.
- **Starvation counter `dcount`:**
  - A data grant while `ic_req` is high increments `dcount` (saturating).
  - An `ic` grant, or IDLE with `ic_req` low, clears it.
- **On grant:** register owner, `q_mem`, `q_paddr`, `q_write` (1 for `dw` only) and `q_i_d` (1 for `ic` only). Set `q_req`=1, clear the nibble counter `ncnt`, go to RD or WR.
- **RD:** each `q_wstrobe_i` (owner `ic`) or `q_wstrobe_d` (owner `dr`) is forwarded combinationally to the owner's `*_strobe` and increments `ncnt`.
  - On a strobe with `ncnt == 2*LINE_LENGTH-1`: next cycle `q_req`=0, owner `*_done`=1, state IDLE.
- **WR:** `q_dwrite = dw_data` combinationally. `dw_rstrobe = q_rstrobe_d`.
  - On the last `q_rstrobe_d` (`ncnt == 2*LINE_LENGTH-1`): next cycle `q_req`=0, `dw_done`=1, state WR_TAIL.
  - WR_TAIL then goes to IDLE unconditionally.
- **Outside WR:** `q_dwrite` = 0 and `dw_rstrobe` = 0.
- **Unexpected strobes:** any strobe in IDLE/WR_TAIL, or a strobe that does not match the owner, sets `err`. The strobe is not forwarded and does not count. `err` clears only on reset.
- **Widths:**
  - `ncnt` is $clog2(2*LINE_LENGTH) bits and wraps to 0 at the end of the burst.
  - `dcount` is $clog2(MAX_D+1) bits.
- **Reset mid-burst:** all state is discarded. No `done` is issued. Requesters re-request, because the controller is reset by the same `reset`.

## Timing
- **Reset values:**
  - `q_req`, `q_i_d`, `q_mem`, `q_write` = 0; `q_paddr` = 0.
  - All `*_done` and all forwarded strobes = 0.
  - `err` = 0; state IDLE; `ncnt` = 0; `dcount` = 0.
- **Outputs:** `q_*` command outputs and `*_done` are registered. Strobes and `q_dwrite` are combinational pass-through, 0 cycles.
- **Grant latency:** request seen in IDLE at cycle t gives `q_req`=1 at t+1.
- **Read turnaround:** last strobe at t → `done` and IDLE at t+1 → next `q_req` at t+2. The controller is back in its idle state at t+1 and sees `q_req`=0.
- **Write turnaround:** last `rstrobe` at t → `done` at t+1 (WR_TAIL) → IDLE at t+2 → next `q_req` at t+3.
- **Power-up init:** `q_req` may rise during the controller's init sequence. It is simply held until the controller accepts it; no timeout.
- **Simultaneous requests in one IDLE cycle:** exactly one grant. Others wait with no loss.

## Test plan
- **Single ic fill:** `ic_req`=1, `ic_addr`=0x12345 (LINE_LENGTH=4, PA=24) → `q_paddr`=0x12345, `q_i_d`=1, `q_write`=0 one cycle later. Exactly 8 `ic_strobe` pulses, `ic_done` the cycle after the 8th, `q_req`=0 with it.
- **Writeback:** `dw_req`, `dw_data` stepping 0x1..0x8 → `q_dwrite` follows, 8 `dw_rstrobe`, `dw_done` after the 8th. `q_req` low ≥2 cycles before the next grant.
- **All three requests in the same cycle:** grant order `dw`, `dr`, `ic`. Each `done` before the next `q_req`.
- **Starvation (MAX_D=4):** `ic_req` held while `dr` re-requests continuously → `ic` granted after 4 `dr` bursts, `dcount` cleared.
- **Stray strobe:** `q_wstrobe_d` pulsed in IDLE → `err`=1 and stays set, no `dr_strobe`, `ncnt` unchanged.
- **Reset mid-read:** `reset` after 3 of 8 strobes → next cycle all outputs at reset values, no `ic_done`. Re-request completes normally.
